// File: rtl/alu_pkg.sv
// Opcode encoding and opcode width shared by the pipelined ALU and its core.
package alu_pkg;

  localparam int unsigned OPW = 3;

  typedef enum logic [OPW-1:0] {
    OP_OR      = 3'b000,
    OP_XOR     = 3'b001,
    OP_ANDXNOR = 3'b010,
    OP_NANDXOR = 3'b011,
    OP_AND     = 3'b100,
    OP_ADD     = 3'b101,
    OP_SUB     = 3'b110,
    OP_PASSC   = 3'b111
  } alu_op_e;

endpackage

// File: rtl/alu_pipe_if.sv
// Operand/result valid-ready bus of alu_pipe; slave is the ALU side.
interface alu_pipe_if #(
  parameter int unsigned WIDTH = 32
);
  import alu_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [OPW-1:0]   op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] C;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Z;
  logic             out_zero;
  logic             out_carry;

  modport master (
    output in_valid, op, A, B, C, out_ready,
    input  in_ready, out_valid, Z, out_zero, out_carry
  );

  modport slave (
    input  in_valid, op, A, B, C, out_ready,
    output in_ready, out_valid, Z, out_zero, out_carry
  );

endinterface

// File: rtl/alu_core.sv
// Purely combinational ALU datapath; carry is the ADD carry-out or SUB borrow.
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  alu_op_e          op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  output logic [WIDTH-1:0] Z,
  output logic             carry
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  // One extra bit exposes carry-out on add and borrow on subtract
  always_comb begin
    sum   = {1'b0, A} + {1'b0, B};
    diff  = {1'b0, A} - {1'b0, B};
    Z     = '0;
    carry = 1'b0;
    case (op)
      OP_OR:      Z = A | B;
      OP_XOR:     Z = A ^ B;
      OP_ANDXNOR: Z = A & ~(B ^ C);
      OP_NANDXOR: Z = ~((A ^ B) & C);
      OP_AND:     Z = A & B;
      OP_ADD: begin
        Z     = sum[WIDTH-1:0];
        carry = sum[WIDTH];
      end
      OP_SUB: begin
        Z     = diff[WIDTH-1:0];
        carry = diff[WIDTH];
      end
      OP_PASSC:   Z = C;
      default:    Z = '0;
    endcase
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU pipeline: operand register, then result register.
// Define ALU_PIPE_FLAGS_EN to register zero/carry flags alongside the result.
module alu_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned OPW   = alu_pkg::OPW
) (
  input logic       clk,
  input logic       rst,
  alu_pipe_if.slave bus
);
  import alu_pkg::alu_op_e;

  if (OPW != alu_pkg::OPW) begin : g_bad_opw
    $fatal(1, "alu_pipe: OPW must be 3");
  end
  if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
    $fatal(1, "alu_pipe: WIDTH must be within 1..64");
  end

  typedef struct packed {
    alu_op_e          op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
  } beat_t;

  logic             s1_valid;
  beat_t            s1_q;
  logic             s2_valid;
  logic [WIDTH-1:0] z_q;
  logic             s2_load;
  logic [WIDTH-1:0] core_z;
  logic             core_carry;

  // Each stage moves when the next one is empty or draining this cycle
  assign s2_load      = s1_valid && (!s2_valid || bus.out_ready);
  assign bus.in_ready = !rst && (!s1_valid || !s2_valid || bus.out_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (bus.in_ready) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_q <= '{op: alu_op_e'(bus.op), a: bus.A, b: bus.B, c: bus.C};
      end
    end
  end

  alu_core #(.WIDTH(WIDTH)) u_core (
    .op    (s1_q.op),
    .A     (s1_q.a),
    .B     (s1_q.b),
    .C     (s1_q.c),
    .Z     (core_z),
    .carry (core_carry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      z_q      <= '0;
    end else if (s2_load) begin
      s2_valid <= 1'b1;
      z_q      <= core_z;
    end else if (bus.out_ready) begin
      s2_valid <= 1'b0;
    end
  end

  assign bus.out_valid = s2_valid;
  assign bus.Z         = z_q;

`ifdef ALU_PIPE_FLAGS_EN
  logic zero_q;
  logic carry_q;

  // Flags travel with the result they describe
  always_ff @(posedge clk) begin
    if (rst) begin
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
    end else if (s2_load) begin
      zero_q  <= (core_z == '0);
      carry_q <= core_carry;
    end
  end

  assign bus.out_zero  = zero_q;
  assign bus.out_carry = carry_q;
`else
  logic unused_carry;
  assign unused_carry  = core_carry;
  assign bus.out_zero  = 1'b0;
  assign bus.out_carry = 1'b0;
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// Randomised and directed bench for alu_pipe against a queue-based reference model.
module tb_alu_pipe;
  import alu_pkg::*;

  localparam int unsigned W = 32;

  typedef struct {
    logic [63:0] z;
    logic        zf;
    logic        cf;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_pipe_if #(.WIDTH(W))  bus ();
  alu_pipe_if #(.WIDTH(1))  bus1 ();
  alu_pipe_if #(.WIDTH(64)) bus64 ();

  alu_pipe #(.WIDTH(W))  dut   (.clk(clk), .rst(rst), .bus(bus));
  alu_pipe #(.WIDTH(1))  dut1  (.clk(clk), .rst(rst), .bus(bus1));
  alu_pipe #(.WIDTH(64)) dut64 (.clk(clk), .rst(rst), .bus(bus64));

  int   n_cmp = 0;
  int   n_err = 0;
  int   n_out = 0;
  int   cyc   = 0;
  bit   lat_check = 1'b0;
  exp_t q[$];
  exp_t mon_e;
  logic stall_q = 1'b0;
  logic [63:0] zhold_q = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Per-bit truth tables for the logic ops, plain arithmetic for the rest
  function automatic exp_t model(input int op, input logic [63:0] a, b, c, input int w);
    exp_t        e;
    logic [63:0] mask;
    logic [7:0]  tab;
    logic [64:0] wide;
    mask  = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    e.z   = '0;
    e.zf  = 1'b0;
    e.cf  = 1'b0;
    e.acc = 0;
    case (op)
      0:       tab = 8'b11111100;
      1:       tab = 8'b00111100;
      2:       tab = 8'b10010000;
      3:       tab = 8'b11010111;
      4:       tab = 8'b11000000;
      default: tab = 8'b00000000;
    endcase
    if (op <= 4) begin
      for (int i = 0; i < w; i++) e.z[i] = tab[{a[i], b[i], c[i]}];
    end else if (op == 5) begin
      wide = 65'(a & mask) + 65'(b & mask);
      e.z  = (a + b) & mask;
      e.cf = wide > 65'(mask);
    end else if (op == 6) begin
      e.z  = (a - b) & mask;
      e.cf = (a & mask) < (b & mask);
    end else begin
      e.z = c & mask;
    end
`ifdef ALU_PIPE_FLAGS_EN
    e.zf = (e.z == 64'd0);
`else
    e.cf = 1'b0;
`endif
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Occupancy-based expectations for the 32-bit instance, checked mid-cycle
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      stall_q = 1'b0;
      chk("in_ready_in_reset", 64'(bus.in_ready), 64'd0);
    end else begin
      chk("in_ready", 64'(bus.in_ready), 64'(q.size() < 2 || bus.out_ready));
      chk("out_valid", 64'(bus.out_valid), 64'(q.size() > 0 && (cyc - q[0].acc) >= 2));
      if (stall_q) chk("z_hold_stalled", 64'(bus.Z), zhold_q);
`ifndef ALU_PIPE_FLAGS_EN
      chk("flags_off", 64'({bus.out_zero, bus.out_carry}), 64'd0);
`endif
      if (bus.out_valid && bus.out_ready) begin
        n_out++;
        if (q.size() == 0) begin
          chk("spurious_out_valid", 64'(bus.out_valid), 64'd0);
        end else begin
          mon_e = q.pop_front();
          chk("Z", 64'(bus.Z), mon_e.z);
          chk("out_zero", 64'(bus.out_zero), 64'(mon_e.zf));
          chk("out_carry", 64'(bus.out_carry), 64'(mon_e.cf));
          if (lat_check) chk("latency", 64'(cyc - mon_e.acc), 64'd2);
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        mon_e     = model(int'(bus.op), 64'(bus.A), 64'(bus.B), 64'(bus.C), W);
        mon_e.acc = cyc;
        q.push_back(mon_e);
      end
      stall_q = bus.out_valid && !bus.out_ready;
      zhold_q = 64'(bus.Z);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int op, input logic [31:0] a, b, c);
    bit acc;
    int guard;
    guard        = 0;
    bus.in_valid = 1'b1;
    bus.op       = 3'(op);
    bus.A        = a;
    bus.B        = b;
    bus.C        = c;
    do begin
      @(negedge clk);
      acc = bus.in_ready;
      tick();
      guard++;
    end while (!acc && guard < 50);
    if (!acc) chk("send_timeout", 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   sent;
    int   out0;
    exp_t e;
    logic [31:0] ra, rb;

    rst            = 1'b1;
    bus.in_valid   = 1'b0;
    bus.out_ready  = 1'b1;
    bus.op         = '0;
    bus.A          = '0;
    bus.B          = '0;
    bus.C          = '0;
    bus1.in_valid  = 1'b0;
    bus1.out_ready = 1'b1;
    bus1.op        = '0;
    bus1.A         = '0;
    bus1.B         = '0;
    bus1.C         = '0;
    bus64.in_valid  = 1'b0;
    bus64.out_ready = 1'b1;
    bus64.op        = '0;
    bus64.A         = '0;
    bus64.B         = '0;
    bus64.C         = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset_Z", 64'(bus.Z), 64'd0);
    chk("reset_out_zero", 64'(bus.out_zero), 64'd0);
    chk("reset_out_carry", 64'(bus.out_carry), 64'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_release", 64'(bus.in_ready), 64'd1);
    tick();

    // Legacy logic ops over every replicated-bit operand pattern, back to back
    lat_check = 1'b1;
    for (int op = 0; op < 4; op++) begin
      for (int p = 0; p < 8; p++) begin
        send(op, {W{p[2]}}, {W{p[1]}}, {W{p[0]}});
      end
    end
    send(5, 32'hFFFF_FFFF, 32'd1, 32'd0);
    send(6, 32'd3, 32'd5, 32'd0);
    repeat (4) tick();

    // Random traffic with random backpressure
    lat_check = 1'b0;
    for (int i = 0; i < 300; i++) begin
      ra            = $urandom;
      rb            = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.op        = 3'($urandom_range(0, 7));
      bus.A         = ra;
      bus.B         = rb;
      bus.C         = $urandom;
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) tick();
    chk("random_drained", 64'(q.size()), 64'd0);

    // Ten-beat stream with downstream stalled for cycles 4..8
    sent = 0;
    out0 = n_out;
    for (int i = 0; i < 40; i++) begin
      bus.out_ready = !(i >= 4 && i <= 8);
      bus.in_valid  = (sent < 10);
      bus.op        = 3'($urandom_range(0, 7));
      bus.A         = $urandom;
      bus.B         = $urandom;
      bus.C         = $urandom;
      @(negedge clk);
      if (i == 6) chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
      if (bus.in_valid && bus.in_ready) sent++;
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    chk("stream_results", 64'(n_out - out0), 64'd10);

    // Reset with two beats held in the pipe
    bus.out_ready = 1'b0;
    send(7, 32'd0, 32'd0, 32'h1234_5678);
    send(5, 32'd7, 32'd9, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("in_ready_during_rst", 64'(bus.in_ready), 64'd0);
    tick();
    rst           = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("rst_flush_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_flush_in_ready", 64'(bus.in_ready), 64'd1);
    repeat (4) tick();

    // Width extremes: pass-through of all-ones C, then a wrapping 64-bit add
    bus1.in_valid  = 1'b1;
    bus1.op        = 3'd7;
    bus1.A         = 1'($urandom);
    bus1.B         = 1'($urandom);
    bus1.C         = 1'b1;
    bus64.in_valid = 1'b1;
    bus64.op       = 3'd7;
    bus64.A        = {$urandom, $urandom};
    bus64.B        = {$urandom, $urandom};
    bus64.C        = '1;
    tick();
    bus1.in_valid = 1'b0;
    bus64.op      = 3'd5;
    bus64.A       = '1;
    bus64.B       = 64'd1;
    bus64.C       = '0;
    tick();
    bus64.in_valid = 1'b0;
    @(negedge clk);
    chk("w1_out_valid", 64'(bus1.out_valid), 64'd1);
    chk("w1_passc", 64'(bus1.Z), 64'd1);
    chk("w1_flags", 64'({bus1.out_zero, bus1.out_carry}), 64'd0);
    chk("w64_out_valid", 64'(bus64.out_valid), 64'd1);
    chk("w64_passc", bus64.Z, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("w64_flags", 64'({bus64.out_zero, bus64.out_carry}), 64'd0);
    tick();
    e = model(5, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 64);
    @(negedge clk);
    chk("w64_add_Z", bus64.Z, e.z);
    chk("w64_add_zero", 64'(bus64.out_zero), 64'(e.zf));
    chk("w64_add_carry", 64'(bus64.out_carry), 64'(e.cf));
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
